// File: rtl/svfloat_div_iter.sv
// Iterative floating-point divider: one restoring-division quotient bit per cycle,
// round-to-nearest-even, subnormals flushed to zero, valid/ready on both sides.

package svfloat;
  typedef struct packed {
    logic        sign;
    logic [7:0]  exponent;
    logic [22:0] mantissa;
  } float32;
endpackage

module svfloat_div_iter #(
  parameter type float = svfloat::float32
) (
  input  logic clk,
  input  logic rst,
  input  logic in_valid,
  output logic in_ready,
  input  float lhs,
  input  float rhs,
  output logic out_valid,
  input  logic out_ready,
  output float res
);
  localparam int unsigned EW   = $bits(lhs.exponent);
  localparam int unsigned MW   = $bits(lhs.mantissa);
  localparam int unsigned BIAS = 2 ** (EW - 1) - 1;
  localparam int unsigned SW   = MW + 1;          // significand with hidden bit
  localparam int unsigned RW   = MW + 2;          // partial remainder
  localparam int unsigned QW   = MW + 3;          // quotient bits incl. normalise + guard
  localparam int unsigned XW   = EW + 2;          // signed working exponent
  localparam int unsigned CW   = $clog2(QW + 1);

  typedef enum logic [1:0] {IDLE, DIV, ROUND, DONE} state_t;

  state_t               state, state_n;
  logic                 sign_q;
  logic signed [XW-1:0] exp_q;
  logic [SW-1:0]        dvs;
  logic [RW-1:0]        rem;
  logic [QW-1:0]        quo;
  logic [CW-1:0]        cnt;

  logic                 a_zero, a_inf, a_nan, b_zero, b_inf, b_nan;
  logic                 spec_hit;
  float                 spec_res;
  logic                 rem_ge;
  logic [RW-1:0]        rem_sub;
  logic [QW-1:0]        qn;
  logic signed [XW-1:0] en;
  logic                 guard, sticky, round_up;
  logic [MW+1:0]        sig_r;
  float                 round_res;

  // Operand classification and direct results for special cases
  always_comb begin
    a_zero   = (lhs.exponent == '0);
    b_zero   = (rhs.exponent == '0);
    a_inf    = (lhs.exponent == '1) && (lhs.mantissa == '0);
    b_inf    = (rhs.exponent == '1) && (rhs.mantissa == '0);
    a_nan    = (lhs.exponent == '1) && (lhs.mantissa != '0);
    b_nan    = (rhs.exponent == '1) && (rhs.mantissa != '0);
    spec_hit = 1'b1;
    spec_res = '0;
    if (a_nan || b_nan || (a_zero && b_zero) || (a_inf && b_inf)) begin
      spec_res.exponent         = '1;
      spec_res.mantissa[MW-1]   = 1'b1;
    end else if (a_inf || b_zero) begin
      spec_res.sign     = lhs.sign ^ rhs.sign;
      spec_res.exponent = '1;
    end else if (a_zero || b_inf) begin
      spec_res.sign     = lhs.sign ^ rhs.sign;
    end else begin
      spec_hit          = 1'b0;
    end
  end

  // One restoring-division step
  always_comb begin
    rem_ge  = (rem >= {1'b0, dvs});
    rem_sub = rem_ge ? (rem - {1'b0, dvs}) : rem;
  end

  // Normalise, round to nearest even, then range-check the exponent
  always_comb begin
    qn = quo;
    en = exp_q;
    if (!quo[QW-1]) begin
      qn = {quo[QW-2:0], 1'b0};
      en = exp_q - XW'(1);
    end
    guard    = qn[1];
    sticky   = qn[0] | (rem != '0);
    round_up = guard & (sticky | qn[2]);
    sig_r    = {1'b0, qn[QW-1:2]} + (MW + 2)'(round_up);
    round_res      = '0;
    round_res.sign = sign_q;
    if (sig_r[MW+1]) begin
      en                 = en + XW'(1);
      round_res.mantissa = sig_r[MW:1];
    end else begin
      round_res.mantissa = sig_r[MW-1:0];
    end
    round_res.exponent = en[EW-1:0];
    if (en >= $signed(XW'(2 ** EW - 1))) begin
      round_res.exponent = '1;
      round_res.mantissa = '0;
    end else if (en <= $signed(XW'(0))) begin
      round_res.exponent = '0;
      round_res.mantissa = '0;
    end
  end

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  // Next-state logic
  always_comb begin
    state_n = state;
    case (state)
      IDLE:    if (in_valid) state_n = spec_hit ? DONE : DIV;
      DIV:     if (cnt == CW'(QW - 1)) state_n = ROUND;
      ROUND:   state_n = DONE;
      DONE:    if (out_ready) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // Datapath and registered handshake outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      res       <= '0;
      sign_q    <= 1'b0;
      exp_q     <= '0;
      dvs       <= '0;
      rem       <= '0;
      quo       <= '0;
      cnt       <= '0;
    end else begin
      in_ready  <= (state_n == IDLE);
      out_valid <= (state_n == DONE);
      case (state)
        IDLE: begin
          if (in_valid) begin
            sign_q <= lhs.sign ^ rhs.sign;
            exp_q  <= XW'(lhs.exponent) - XW'(rhs.exponent) + XW'(BIAS);
            dvs    <= {1'b1, rhs.mantissa};
            rem    <= {2'b01, lhs.mantissa};
            quo    <= '0;
            cnt    <= '0;
            if (spec_hit) res <= spec_res;
          end
        end
        DIV: begin
          quo <= {quo[QW-2:0], rem_ge};
          rem <= {rem_sub[RW-2:0], 1'b0};
          cnt <= cnt + CW'(1);
        end
        ROUND:   res <= round_res;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_svfloat_div_iter.sv
// Scoreboard bench for the iterative float divider.
module tb_svfloat_div_iter;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic            rst, in_valid, in_ready, out_valid, out_ready;
  svfloat::float32 lhs, rhs, res;

  int          n_checks = 0;
  int          n_fail   = 0;
  logic [31:0] sb[$];

  svfloat_div_iter dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .lhs(lhs), .rhs(rhs),
    .out_valid(out_valid), .out_ready(out_ready), .res(res)
  );

  localparam int NN = 7;
  localparam logic [31:0] NORM_A [NN] = '{32'h40C00000, 32'h3F800000, 32'h40000000, 32'h3F800000,
                                          32'h40000000, 32'hC0C00000, 32'h41100000};
  localparam logic [31:0] NORM_B [NN] = '{32'h40000000, 32'h40400000, 32'h40400000, 32'h3F800000,
                                          32'h3F000000, 32'h40000000, 32'h40400000};
  localparam logic [31:0] NORM_E [NN] = '{32'h40400000, 32'h3EAAAAAB, 32'h3F2AAAAB, 32'h3F800000,
                                          32'h40800000, 32'hC0400000, 32'h40400000};

  localparam int NS = 11;
  localparam logic [31:0] SPEC_A [NS] = '{32'h3F800000, 32'h80000000, 32'h7F800000, 32'hBF800000,
                                          32'h7FC00001, 32'h3F800000, 32'h7F800000, 32'hFF800000,
                                          32'h00000000, 32'h00400000, 32'hBF800000};
  localparam logic [31:0] SPEC_B [NS] = '{32'h00000000, 32'h00000000, 32'h7F800000, 32'h7F800000,
                                          32'h3F800000, 32'hFF800001, 32'h3F800000, 32'h3F800000,
                                          32'h40A00000, 32'h3F800000, 32'h00000000};
  localparam logic [31:0] SPEC_E [NS] = '{32'h7F800000, 32'h7FC00000, 32'h7FC00000, 32'h80000000,
                                          32'h7FC00000, 32'h7FC00000, 32'h7F800000, 32'hFF800000,
                                          32'h00000000, 32'h00000000, 32'hFF800000};

  // Present one operation, wait for its result (bounded), retire it.
  // lat counts cycles after the accept edge: 1 = first cycle after accept.
  task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic [31:0] e,
                        input bit push, output logic [31:0] got, output int lat,
                        output bit to, output bit rdy_seen);
    int w;
    lhs = a; rhs = b; in_valid = 1'b1;
    w = 0;
    while (!in_ready && w < 100) begin @(posedge clk); #1; w++; end
    @(posedge clk); #1;
    in_valid = 1'b0;
    if (push) sb.push_back(e);
    lat = 1; to = 1'b0; rdy_seen = 1'b0;
    while (!out_valid && !to) begin
      if (in_ready) rdy_seen = 1'b1;
      if (lat >= 60) to = 1'b1;
      else begin @(posedge clk); #1; lat++; end
    end
    if (in_ready) rdy_seen = 1'b1;
    got = res;
    out_ready = 1'b1; @(posedge clk); #1; out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; lhs = '0; rhs = '0;
    repeat (3) @(posedge clk);
    #1;
    n_checks++;
    if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset in_ready: got %b expected 1", in_ready); end
    n_checks++;
    if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset out_valid: got %b expected 0", out_valid); end
    n_checks++;
    if (res !== 32'h0) begin n_fail++; $display("FAIL reset res: got %h expected 00000000", res); end
    rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_normal();
    logic [31:0] got, exp_v;
    int lat; bit to, rdy;
    for (int i = 0; i < NN; i++) begin
      run_op(NORM_A[i], NORM_B[i], NORM_E[i], 1'b1, got, lat, to, rdy);
      exp_v = 32'hxxxxxxxx;
      if (sb.size() > 0) exp_v = sb.pop_front();
      n_checks++;
      if (to || got !== exp_v) begin
        n_fail++; $display("FAIL normal[%0d] res: got %h expected %h timeout=%0b", i, got, exp_v, to);
      end
      n_checks++;
      if (lat != 28) begin n_fail++; $display("FAIL normal[%0d] latency: got %0d expected 28", i, lat); end
      n_checks++;
      if (rdy) begin n_fail++; $display("FAIL normal[%0d] in_ready busy: got 1 expected 0", i); end
    end
  endtask

  task automatic test_specials();
    logic [31:0] got, exp_v;
    int lat; bit to, rdy;
    for (int i = 0; i < NS; i++) begin
      run_op(SPEC_A[i], SPEC_B[i], SPEC_E[i], 1'b1, got, lat, to, rdy);
      exp_v = 32'hxxxxxxxx;
      if (sb.size() > 0) exp_v = sb.pop_front();
      n_checks++;
      if (to || got !== exp_v) begin
        n_fail++; $display("FAIL special[%0d] res: got %h expected %h timeout=%0b", i, got, exp_v, to);
      end
      n_checks++;
      if (lat != 1) begin n_fail++; $display("FAIL special[%0d] latency: got %0d expected 1", i, lat); end
    end
  endtask

  task automatic test_range();
    logic [31:0] got, exp_v;
    int lat; bit to, rdy;
    run_op(32'h7F7FFFFF, 32'h3F000000, 32'h7F800000, 1'b1, got, lat, to, rdy);
    exp_v = 32'hxxxxxxxx;
    if (sb.size() > 0) exp_v = sb.pop_front();
    n_checks++;
    if (to || got !== exp_v) begin n_fail++; $display("FAIL overflow res: got %h expected %h", got, exp_v); end
    run_op(32'h00800000, 32'h40000000, 32'h00000000, 1'b1, got, lat, to, rdy);
    exp_v = 32'hxxxxxxxx;
    if (sb.size() > 0) exp_v = sb.pop_front();
    n_checks++;
    if (to || got !== exp_v) begin n_fail++; $display("FAIL underflow res: got %h expected %h", got, exp_v); end
  endtask

  task automatic test_backpressure();
    logic [31:0] exp_v;
    int w, lat;
    lhs = 32'h40C00000; rhs = 32'h40000000; in_valid = 1'b1;
    w = 0;
    while (!in_ready && w < 100) begin @(posedge clk); #1; w++; end
    @(posedge clk); #1;
    in_valid = 1'b0;
    sb.push_back(32'h40400000);
    w = 0;
    while (!out_valid && w < 60) begin @(posedge clk); #1; w++; end
    exp_v = 32'hxxxxxxxx;
    if (sb.size() > 0) exp_v = sb.pop_front();
    // next operation waits at the input while the result is stalled
    lhs = 32'h3F800000; rhs = 32'h40400000; in_valid = 1'b1;
    for (int k = 0; k < 10; k++) begin
      n_checks++;
      if (res !== exp_v || out_valid !== 1'b1 || in_ready !== 1'b0) begin
        n_fail++;
        $display("FAIL backpressure hold[%0d]: res %h out_valid %b in_ready %b expected %h 1 0",
                 k, res, out_valid, in_ready, exp_v);
      end
      @(posedge clk); #1;
    end
    out_ready = 1'b1; @(posedge clk); #1; out_ready = 1'b0;
    n_checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      n_fail++; $display("FAIL retire: out_valid %b in_ready %b expected 0 1", out_valid, in_ready);
    end
    sb.push_back(32'h3EAAAAAB);
    @(posedge clk); #1;
    in_valid = 1'b0;
    n_checks++;
    if (in_ready !== 1'b0) begin n_fail++; $display("FAIL accept after retire: in_ready %b expected 0", in_ready); end
    lat = 1;
    while (!out_valid && lat < 60) begin @(posedge clk); #1; lat++; end
    exp_v = 32'hxxxxxxxx;
    if (sb.size() > 0) exp_v = sb.pop_front();
    n_checks++;
    if (res !== exp_v || lat != 28) begin
      n_fail++; $display("FAIL queued op: res %h lat %0d expected %h lat 28", res, lat, exp_v);
    end
    out_ready = 1'b1; @(posedge clk); #1; out_ready = 1'b0;
  endtask

  task automatic test_reset_mid_div();
    logic [31:0] got, exp_v;
    int w, lat; bit to, rdy, seen;
    lhs = 32'h40C00000; rhs = 32'h40000000; in_valid = 1'b1;
    w = 0;
    while (!in_ready && w < 100) begin @(posedge clk); #1; w++; end
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (9) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    n_checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      n_fail++; $display("FAIL async reset: out_valid %b in_ready %b expected 0 1", out_valid, in_ready);
    end
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    seen = 1'b0;
    repeat (40) begin @(posedge clk); #1; if (out_valid) seen = 1'b1; end
    n_checks++;
    if (seen || in_ready !== 1'b1) begin
      n_fail++; $display("FAIL abandoned op: out_valid seen %b in_ready %b expected 0 1", seen, in_ready);
    end
    run_op(32'h40C00000, 32'h40000000, 32'h40400000, 1'b1, got, lat, to, rdy);
    exp_v = 32'hxxxxxxxx;
    if (sb.size() > 0) exp_v = sb.pop_front();
    n_checks++;
    if (to || got !== exp_v || lat != 28) begin
      n_fail++; $display("FAIL op after reset: res %h lat %0d expected %h lat 28", got, lat, exp_v);
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  initial begin
    test_reset();
    test_normal();
    test_specials();
    test_range();
    test_backpressure();
    test_reset_mid_div();
    n_checks++;
    if (sb.size() != 0) begin n_fail++; $display("FAIL scoreboard drain: %0d left expected 0", sb.size()); end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
